fixed_point_divider: RTL and testbench

//   Sequential signed fixed-point divider; the inverse of the pipelined fixed-point multiplier.

---
 rtl/fixed_point_divider.sv | 169 ++++++++++++++++
 tb/tb_fixed_point_divider.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fixed_point_divider.sv
// Sequential signed fixed-point divider: quotient = (dividend << FIXED_POINT_POSITION) / divisor,
// computed by restoring division one bit per cycle, with saturation and divide-by-zero flagging.
module fixed_point_divider #(
    parameter int FACTOR_WIDTH         = 16,
    parameter int FIXED_POINT_POSITION = 10
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    start_in,
    input  logic [FACTOR_WIDTH-1:0] dividend_in,
    input  logic [FACTOR_WIDTH-1:0] divisor_in,
    output logic                    ready_out,
    output logic                    valid_out,
    output logic [FACTOR_WIDTH-1:0] quotient_out,
    output logic                    overflow_out,
    output logic                    div_by_zero_out
);

    localparam int W        = FACTOR_WIDTH;
    localparam int F        = FIXED_POINT_POSITION;
    localparam int NUM_BITS = W + F;
    localparam int N        = NUM_BITS;
    localparam int CW       = $clog2(N);

    localparam logic [N-1:0] POS_LIM = {{(N-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [N-1:0] NEG_LIM = {{(N-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] Q_MAX   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] Q_MIN   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t         state_q, state_d;
    logic           sign_q, sign_d;
    logic           dvd_neg_q, dvd_neg_d;
    logic           dbz_q, dbz_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [N-1:0]   num_q, num_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic [W-1:0]   quot_q, quot_d;
    logic           ovf_q, ovf_d;
    logic           dbz_out_q, dbz_out_d;

    logic [W:0]     rem_shift;
    logic [W-1:0]   rem_sub;
    logic           rem_ge;

    // Magnitude is unsigned W bits, so the most negative input maps exactly to 2^(W-1).
    function automatic logic [W-1:0] mag_of(input logic [W-1:0] v);
        return v[W-1] ? ((~v) + W'(1)) : v;
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_in) state_d = (divisor_in == '0) ? FINISH : CALC;
            CALC:    if (cnt_q == '0) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sign_d    = sign_q;
        dvd_neg_d = dvd_neg_q;
        dbz_d     = dbz_q;
        dvs_d     = dvs_q;
        num_d     = num_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        quot_d    = quot_q;
        ovf_d     = ovf_q;
        dbz_out_d = dbz_out_q;

        rem_shift = {rem_q, num_q[N-1]};
        rem_ge    = (rem_shift >= {1'b0, dvs_q});
        rem_sub   = rem_shift[W-1:0] - dvs_q;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    sign_d    = dividend_in[W-1] ^ divisor_in[W-1];
                    dvd_neg_d = dividend_in[W-1];
                    dbz_d     = (divisor_in == '0);
                    dvs_d     = mag_of(divisor_in);
                    num_d     = {mag_of(dividend_in), {F{1'b0}}};
                    rem_d     = '0;
                    quo_d     = '0;
                    cnt_d     = CW'(N - 1);
                end
            end
            CALC: begin
                num_d = {num_q[N-2:0], 1'b0};
                rem_d = rem_ge ? rem_sub : rem_shift[W-1:0];
                quo_d = {quo_q[N-2:0], rem_ge};
                cnt_d = cnt_q - CW'(1);
            end
            FINISH: begin
                valid_d   = 1'b1;
                ovf_d     = 1'b0;
                dbz_out_d = dbz_q;
                if (dbz_q) begin
                    quot_d = dvd_neg_q ? Q_MIN : Q_MAX;
                end else if (sign_q) begin
                    if (quo_q > NEG_LIM) begin
                        quot_d = Q_MIN;
                        ovf_d  = 1'b1;
                    end else begin
                        quot_d = W'(0) - quo_q[W-1:0];
                    end
                end else if (quo_q > POS_LIM) begin
                    quot_d = Q_MAX;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = quo_q[W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sign_q    <= 1'b0;
            dvd_neg_q <= 1'b0;
            dbz_q     <= 1'b0;
            dvs_q     <= '0;
            num_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            quot_q    <= '0;
            ovf_q     <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            sign_q    <= sign_d;
            dvd_neg_q <= dvd_neg_d;
            dbz_q     <= dbz_d;
            dvs_q     <= dvs_d;
            num_q     <= num_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            quot_q    <= quot_d;
            ovf_q     <= ovf_d;
            dbz_out_q <= dbz_out_d;
        end
    end

    always_comb begin
        ready_out       = (state_q == IDLE);
        valid_out       = valid_q;
        quotient_out    = quot_q;
        overflow_out    = ovf_q;
        div_by_zero_out = dbz_out_q;
    end

endmodule

// File: tb/tb_fixed_point_divider.sv
// Directed bench for fixed_point_divider: Q5.10 vectors with hand-computed quotients, latency,
// saturation, divide-by-zero, busy-start rejection, back-to-back accept and mid-calc reset.
module tb_fixed_point_divider;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        start_in = 1'b0;
    logic [15:0] dividend_in = '0;
    logic [15:0] divisor_in = '0;
    logic        ready_out, valid_out, overflow_out, div_by_zero_out;
    logic [15:0] quotient_out;

    int checks = 0;
    int errors = 0;

    fixed_point_divider dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .dividend_in     (dividend_in),
        .divisor_in      (divisor_in),
        .ready_out       (ready_out),
        .valid_out       (valid_out),
        .quotient_out    (quotient_out),
        .overflow_out    (overflow_out),
        .div_by_zero_out (div_by_zero_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for valid_out; lat counts edges after the accept edge.
    task automatic wait_result(output int lat);
        lat = 0;
        while (valid_out !== 1'b1 && lat < 100) begin
            @(negedge clk_in);
            lat++;
        end
    endtask

    task automatic do_div(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                          input logic [15:0] eq, input logic eovf, input logic edbz, input int elat);
        int lat;
        @(negedge clk_in);
        chk({tag, "_ready"}, 32'(ready_out), 32'd1);
        start_in    = 1'b1;
        dividend_in = dvd;
        divisor_in  = dvs;
        @(negedge clk_in);
        start_in = 1'b0;
        wait_result(lat);
        chk({tag, "_latency"}, 32'(lat), 32'(elat));
        chk({tag, "_q"}, 32'(quotient_out), 32'(eq));
        chk({tag, "_ovf"}, 32'(overflow_out), 32'(eovf));
        chk({tag, "_dbz"}, 32'(div_by_zero_out), 32'(edbz));
        @(negedge clk_in);
        chk({tag, "_pulse"}, 32'(valid_out), 32'd0);
        chk({tag, "_hold"}, 32'(quotient_out), 32'(eq));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;

        repeat (3) @(negedge clk_in);
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_q", 32'(quotient_out), 32'd0);
        chk("rst_flags", {30'd0, overflow_out, div_by_zero_out}, 32'd0);
        rst_in = 1'b0;

        do_div("3_div_2",      16'h0C00, 16'h0800, 16'h0600, 1'b0, 1'b0, 27);
        do_div("m3_div_2",     16'hF400, 16'h0800, 16'hFA00, 1'b0, 1'b0, 27);
        do_div("1_div_3",      16'h0400, 16'h0C00, 16'h0155, 1'b0, 1'b0, 27);
        do_div("m1_div_3",     16'hFC00, 16'h0C00, 16'hFEAB, 1'b0, 1'b0, 27);
        do_div("ovf_pos",      16'h4000, 16'h0100, 16'h7FFF, 1'b1, 1'b0, 27);
        do_div("ovf_neg",      16'hC000, 16'h0100, 16'h8000, 1'b1, 1'b0, 27);
        do_div("min_div_m1",   16'h8000, 16'hFC00, 16'h7FFF, 1'b1, 1'b0, 27);
        do_div("min_div_1",    16'h8000, 16'h0400, 16'h8000, 1'b0, 1'b0, 27);
        do_div("lsb_neg",      16'hFFFF, 16'h0400, 16'hFFFF, 1'b0, 1'b0, 27);
        do_div("dbz_pos",      16'h1400, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1);
        do_div("dbz_neg",      16'hEC00, 16'h0000, 16'h8000, 1'b0, 1'b1, 1);
        do_div("after_dbz",    16'h0800, 16'h0400, 16'h0800, 1'b0, 1'b0, 27);
        do_div("zero_zero",    16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1);
        do_div("zero_div_neg", 16'h0000, 16'hFC00, 16'h0000, 1'b0, 1'b0, 27);

        // start held through the busy period with changing operands, then a new start in the valid cycle
        @(negedge clk_in);
        start_in    = 1'b1;
        dividend_in = 16'h0C00;
        divisor_in  = 16'h0800;
        @(negedge clk_in);
        lat  = 0;
        seen = 0;
        while (valid_out !== 1'b1 && lat < 100) begin
            dividend_in = 16'h0400 + 16'(lat);
            divisor_in  = 16'h0001;
            @(negedge clk_in);
            lat++;
        end
        chk("hold_latency", 32'(lat), 32'd27);
        chk("hold_q", 32'(quotient_out), 32'h0600);
        chk("hold_ovf", 32'(overflow_out), 32'd0);
        chk("b2b_ready", 32'(ready_out), 32'd1);
        dividend_in = 16'h0400;
        divisor_in  = 16'h0C00;
        @(negedge clk_in);
        start_in = 1'b0;
        wait_result(lat);
        chk("b2b_latency", 32'(lat), 32'd27);
        chk("b2b_q", 32'(quotient_out), 32'h0155);

        // reset 10 cycles into a calculation
        @(negedge clk_in);
        start_in    = 1'b1;
        dividend_in = 16'hF400;
        divisor_in  = 16'h0800;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (10) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("abort_ready", 32'(ready_out), 32'd1);
        chk("abort_q", 32'(quotient_out), 32'd0);
        chk("abort_valid", 32'(valid_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (40) begin
            @(negedge clk_in);
            if (valid_out === 1'b1) seen++;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        chk("abort_flags", {30'd0, overflow_out, div_by_zero_out}, 32'd0);
        do_div("after_abort", 16'hF400, 16'h0800, 16'hFA00, 1'b0, 1'b0, 27);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
